// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer:
// state enum, instruction classes, opcode/funct constants and mux selects.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_JR    = 3'd1,
        CLS_IMM   = 3'd2,
        CLS_LW    = 3'd3,
        CLS_SW    = 3'd4,
        CLS_BEQ   = 3'd5,
        CLS_J     = 3'd6,
        CLS_JAL   = 3'd7
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] MTR_PC4 = 2'b00;
    localparam logic [1:0] MTR_ALU = 2'b01;
    localparam logic [1:0] MTR_MEM = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct to instruction class
// plus an illegal-opcode flag.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic       illegal
);

    always_comb begin
        iclass  = CLS_RTYPE;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: iclass = (funct == FUNCT_JR) ? CLS_JR : CLS_RTYPE;
            OP_ADDI,
            OP_ORI,
            OP_LUI:   iclass = CLS_IMM;
            OP_LW:    iclass = CLS_LW;
            OP_SW:    iclass = CLS_SW;
            OP_BEQ:   iclass = CLS_BEQ;
            OP_J:     iclass = CLS_J;
            OP_JAL:   iclass = CLS_JAL;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// watchdog trap and optional performance counters (MC_PERF_CNT_EN).
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int WDOG_CYCLES = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             halt_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       npc_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       memtoreg,
    output logic             trap,
    output logic             trap_cause,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    state_t          cur_state;
    state_t          nxt_state;
    iclass_t         iclass;
    logic            illegal;
    logic [WD_W-1:0] wdog;
    logic            wdog_hit;
    logic            waiting;
    logic            bus_err;
    logic            retire;
    logic            cause;

    mc_decode u_decode (
        .op      (op),
        .funct   (funct),
        .iclass  (iclass),
        .illegal (illegal)
    );

    assign wdog_hit = (wdog == WD_W'(WDOG_CYCLES - 1));

    always_comb begin
        nxt_state = cur_state;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        npc_sel   = NPC_SEQ;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        reg_dst   = DST_RT;
        memtoreg  = MTR_PC4;
        waiting   = 1'b0;
        bus_err   = 1'b0;
        retire    = 1'b0;
        case (cur_state)
            ST_IDLE: nxt_state = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = ST_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wdog_hit) begin
                        bus_err   = 1'b1;
                        nxt_state = ST_TRAP;
                    end
                end
            end
            ST_DECODE: nxt_state = illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (iclass)
                    CLS_BEQ: begin
                        pc_write = zero;
                        npc_sel  = NPC_BRANCH;
                        retire   = 1'b1;
                    end
                    CLS_J: begin
                        pc_write = 1'b1;
                        npc_sel  = NPC_JUMP;
                        retire   = 1'b1;
                    end
                    CLS_JR: begin
                        pc_write = 1'b1;
                        npc_sel  = NPC_REG;
                        retire   = 1'b1;
                    end
                    CLS_JAL: begin
                        pc_write  = 1'b1;
                        npc_sel   = NPC_JUMP;
                        nxt_state = ST_WB;
                    end
                    CLS_LW,
                    CLS_SW:  nxt_state = ST_MEM;
                    default: nxt_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == CLS_SW);
                if (dmem_ready) begin
                    if (iclass == CLS_SW) retire = 1'b1;
                    else nxt_state = ST_WB;
                end else begin
                    waiting = 1'b1;
                    if (wdog_hit) begin
                        bus_err   = 1'b1;
                        nxt_state = ST_TRAP;
                    end
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                case (iclass)
                    CLS_RTYPE: begin reg_dst = DST_RD; memtoreg = MTR_ALU; end
                    CLS_LW:    begin reg_dst = DST_RT; memtoreg = MTR_MEM; end
                    CLS_JAL:   begin reg_dst = DST_RA; memtoreg = MTR_PC4; end
                    default:   begin reg_dst = DST_RT; memtoreg = MTR_ALU; end
                endcase
            end
            ST_HALT: if (!halt_req) nxt_state = ST_FETCH;
            default: nxt_state = ST_TRAP;
        endcase
        // Retire is the only instruction boundary where a halt request is honoured
        if (retire) nxt_state = halt_req ? ST_HALT : ST_FETCH;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_IDLE;
            wdog      <= '0;
            cause     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            wdog      <= (waiting && !wdog_hit) ? wdog + WD_W'(1) : '0;
            if (cur_state != ST_TRAP && nxt_state == ST_TRAP) cause <= bus_err;
        end
    end

    assign state      = cur_state;
    assign trap       = (cur_state == ST_TRAP);
    assign halted     = (cur_state == ST_HALT);
    assign trap_cause = cause;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] instret;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycles  <= '0;
            instret <= '0;
        end else begin
            cycles <= cycles + CNT_W'(1);
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycles;
    assign instret_cnt = instret;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: instruction timings, handshakes,
// halt/trap behaviour, watchdog expiry and asynchronous reset.
module tb_mc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        halt_req;
    logic        imem_ready;
    logic        dmem_ready;
    logic [2:0]  state;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  npc_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  memtoreg;
    logic        trap;
    logic        trap_cause;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int req_cycles;

`ifdef MC_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;

    mc_sequencer #(.WDOG_CYCLES(4), .CNT_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .halt_req    (halt_req),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .state       (state),
        .imem_req    (imem_req),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .npc_sel     (npc_sel),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .memtoreg    (memtoreg),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
        cyc++;
    endtask

    task automatic run_beq(input logic z);
        op = 6'h04; halt_req = 1'b0; cyc = 0;
        step();                         // FETCH
        halt_req = 1'b1;
        step();                         // DECODE
        step();                         // EXEC
        zero = z;
        #1;
        check("beq_state", 32'(state), 32'(S_EXEC));
        check("beq_pc_write", 32'(pc_write), 32'(z));
        check("beq_npc_sel", 32'(npc_sel), 32'd1);
        step();
        check("beq_halt", 32'(state), 32'(S_HALT));
        check("beq_len", 32'(cyc - 1), 32'd3);
        zero = 1'b0;
    endtask

    initial begin
        reset = 1'b0; op = 6'h00; funct = 6'h21; zero = 1'b0;
        halt_req = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_instret", instret_cnt, 32'd0);

        // addu with zero-wait fetch
        reset = 1'b1;
        #1;
        check("idle", 32'(state), 32'(S_IDLE));
        step();
        check("addu_fetch", 32'(state), 32'(S_FETCH));
        check("addu_imem_req", 32'(imem_req), 32'd1);
        check("addu_ir_write", 32'(ir_write), 32'd1);
        check("addu_pc_write", 32'(pc_write), 32'd1);
        check("addu_npc_sel", 32'(npc_sel), 32'd0);
        step();
        check("addu_decode", 32'(state), 32'(S_DECODE));
        check("addu_dec_pcw", 32'(pc_write), 32'd0);
        step();
        check("addu_exec", 32'(state), 32'(S_EXEC));
        check("addu_exec_rw", 32'(reg_write), 32'd0);
        step();
        check("addu_wb_rw", 32'(reg_write), 32'd1);
        check("addu_reg_dst", 32'(reg_dst), 32'd1);
        check("addu_memtoreg", 32'(memtoreg), 32'd1);
        halt_req = 1'b1;
        step();
        check("addu_halted", 32'(halted), 32'd1);
        check("addu_halt_imem", 32'(imem_req), 32'd0);
        check("addu_instret", instret_cnt, 32'(PERF * 1));

        // lw with dmem_ready delayed three cycles; halt request held mid-instruction
        op = 6'h23; halt_req = 1'b0; cyc = 0;
        step();
        check("lw_fetch", 32'(state), 32'(S_FETCH));
        halt_req = 1'b1;
        step();
        step();
        check("lw_exec_no_halt", 32'(state), 32'(S_EXEC));
        step();
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            if (dmem_req === 1'b1 && state === S_MEM) req_cycles++;
            check("lw_dmem_we", 32'(dmem_we), 32'd0);
            step();
        end
        dmem_ready = 1'b0;
        check("lw_req_cycles", 32'(req_cycles), 32'd4);
        check("lw_wb_state", 32'(state), 32'(S_WB));
        check("lw_memtoreg", 32'(memtoreg), 32'd2);
        check("lw_reg_dst", 32'(reg_dst), 32'd0);
        check("lw_reg_write", 32'(reg_write), 32'd1);
        step();
        check("lw_halt", 32'(state), 32'(S_HALT));
        check("lw_len", 32'(cyc - 1), 32'd8);
        check("lw_instret", instret_cnt, 32'(PERF * 2));

        run_beq(1'b1);
        run_beq(1'b0);

        // jal
        op = 6'h03; halt_req = 1'b0; cyc = 0;
        step();
        halt_req = 1'b1;
        step();
        step();
        check("jal_pc_write", 32'(pc_write), 32'd1);
        check("jal_npc_sel", 32'(npc_sel), 32'd2);
        step();
        check("jal_reg_write", 32'(reg_write), 32'd1);
        check("jal_reg_dst", 32'(reg_dst), 32'd2);
        check("jal_memtoreg", 32'(memtoreg), 32'd0);
        step();
        check("jal_len", 32'(cyc - 1), 32'd4);

        // sw, dmem_ready already high during fetch (no request then)
        op = 6'h2B; halt_req = 1'b0; dmem_ready = 1'b1; cyc = 0;
        step();
        check("sw_fetch_no_dreq", 32'(dmem_req), 32'd0);
        halt_req = 1'b1;
        step();
        step();
        step();
        check("sw_mem", 32'(state), 32'(S_MEM));
        check("sw_dmem_req", 32'(dmem_req), 32'd1);
        check("sw_dmem_we", 32'(dmem_we), 32'd1);
        check("sw_reg_write", 32'(reg_write), 32'd0);
        step();
        dmem_ready = 1'b0;
        check("sw_halt", 32'(state), 32'(S_HALT));
        check("sw_len", 32'(cyc - 1), 32'd4);
        check("sw_instret", instret_cnt, 32'(PERF * 6));

        // illegal opcode with halt_req high: trap wins
        op = 6'h3F; halt_req = 1'b0;
        step();
        halt_req = 1'b1;
        step();
        check("ill_decode", 32'(state), 32'(S_DECODE));
        step();
        check("ill_state", 32'(state), 32'(S_TRAP));
        check("ill_trap", 32'(trap), 32'd1);
        check("ill_cause", 32'(trap_cause), 32'd0);
        check("ill_reg_write", 32'(reg_write), 32'd0);
        check("ill_halted", 32'(halted), 32'd0);
        halt_req = 1'b0;
        step();
        check("ill_sticky", 32'(state), 32'(S_TRAP));

        // ready arriving on the expiry cycle completes the fetch
        reset = 1'b0;
        #1;
        check("rst2_state", 32'(state), 32'(S_IDLE));
        check("rst2_trap", 32'(trap), 32'd0);
        op = 6'h00; funct = 6'h21; imem_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        step();
        check("race_fetch", 32'(state), 32'(S_FETCH));
        step();
        imem_ready = 1'b1;
        #1;
        check("race_ir_write", 32'(ir_write), 32'd1);
        step();
        check("race_decode", 32'(state), 32'(S_DECODE));
        check("race_no_trap", 32'(trap), 32'd0);

        // watchdog expiry on a stalled fetch
        reset = 1'b0;
        #1;
        imem_ready = 1'b0;
        reset = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check("wd_fetch", 32'(state), 32'(S_FETCH));
            step();
        end
        check("wd_trap", 32'(trap), 32'd1);
        check("wd_cause", 32'(trap_cause), 32'd1);

        // asynchronous reset in the middle of FETCH
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        check("mid_fetch", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'(S_IDLE));
        check("mid_rst_imem_req", 32'(imem_req), 32'd0);
        check("mid_rst_cause", 32'(trap_cause), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
